// File: rtl/systolic_feeder.sv
// systolic_feeder: streams per-step operand columns/rows into an NxN systolic
// array. It clears the array at the start of each job, presents one k-step per
// enabled cycle and pulses done once the array accumulators hold C = A*B.
module systolic_feeder #(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int KMAX = 64,
    parameter int KW   = $clog2(KMAX + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [KW-1:0]   k_len,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*W-1:0]  in_a,
    input  logic [N*W-1:0]  in_b,
    output logic            arr_clr,
    output logic            arr_en,
    output logic [N*W-1:0]  a_out,
    output logic [N*W-1:0]  b_out,
    output logic            busy,
    output logic            done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam logic [KW-1:0] KMAX_V = KW'(KMAX);

    state_t           state_q, state_d;
    logic [KW-1:0]    k_reg_q, k_reg_d;
    logic [KW-1:0]    cnt_q, cnt_d;
    logic             arr_clr_q, arr_clr_d;
    logic             arr_en_q, arr_en_d;
    logic             done_q, done_d;
    logic [N*W-1:0]   a_out_q, a_out_d;
    logic [N*W-1:0]   b_out_q, b_out_d;
    logic             accept;

    assign in_ready = (state_q == S_STREAM);
    assign busy     = (state_q != S_IDLE);
    assign accept   = in_valid && in_ready;

    assign arr_clr  = arr_clr_q;
    assign arr_en   = arr_en_q;
    assign done     = done_q;
    assign a_out    = a_out_q;
    assign b_out    = b_out_q;

    // Next-state and registered-output computation; operands default to zero so
    // any cycle without an accepted beat is a harmless bubble for the array.
    always_comb begin
        state_d   = state_q;
        k_reg_d   = k_reg_q;
        cnt_d     = cnt_q;
        arr_clr_d = 1'b0;
        arr_en_d  = 1'b0;
        done_d    = 1'b0;
        a_out_d   = '0;
        b_out_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    k_reg_d   = (k_len > KMAX_V) ? KMAX_V : k_len;
                    cnt_d     = '0;
                    arr_clr_d = 1'b1;
                    state_d   = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (k_reg_q == '0) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (accept) begin
                    a_out_d  = in_a;
                    b_out_d  = in_b;
                    arr_en_d = 1'b1;
                    cnt_d    = cnt_q + KW'(1);
                    if (cnt_q == k_reg_q - KW'(1)) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset that abandons any job.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            k_reg_q   <= '0;
            cnt_q     <= '0;
            arr_clr_q <= 1'b0;
            arr_en_q  <= 1'b0;
            done_q    <= 1'b0;
            a_out_q   <= '0;
            b_out_q   <= '0;
        end else begin
            state_q   <= state_d;
            k_reg_q   <= k_reg_d;
            cnt_q     <= cnt_d;
            arr_clr_q <= arr_clr_d;
            arr_en_q  <= arr_en_d;
            done_q    <= done_d;
            a_out_q   <= a_out_d;
            b_out_q   <= b_out_d;
        end
    end

endmodule
